// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared state/op encodings and wait-counter width for mem_access_ctrl
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - FSM request side and memory side of mem_access_ctrl
interface mem_access_ctrl_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          MemRead;
  logic          MemWrite;
  logic          AddrSel;
  logic [AW-1:0] pc_addr;
  logic [AW-1:0] reg_addr;
  logic [DW-1:0] wdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_re;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;
  logic          stall;
  logic [DW-1:0] rdata;
  logic          rdata_valid;
  logic          req_err;

  // master is the control FSM plus the memory; slave is the access controller
  modport master (
    output MemRead, MemWrite, AddrSel, pc_addr, reg_addr, wdata, mem_rdata,
    input  mem_addr, mem_wdata, mem_re, mem_we, stall, rdata, rdata_valid, req_err
  );

  modport slave (
    input  MemRead, MemWrite, AddrSel, pc_addr, reg_addr, wdata, mem_rdata,
    output mem_addr, mem_wdata, mem_re, mem_we, stall, rdata, rdata_valid, req_err
  );
endinterface

// File: rtl/mem_wait_counter.sv
// rtl/mem_wait_counter.sv - loadable down-counter with zero flag for access wait states
module mem_wait_counter #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - single-port memory access stage with programmable wait states
// Optional MEM_ACCESS_STATS_EN adds rd_count/wr_count completion counters.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int AW          = 8,
  parameter int DW          = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                clock,
  input  logic                reset,
  mem_access_ctrl_if.slave    bus
`ifdef MEM_ACCESS_STATS_EN
  ,
  output logic [15:0]         rd_count,
  output logic [15:0]         wr_count
`endif
);

  generate
    if (WAIT_CYCLES < 0 || WAIT_CYCLES >= (1 << WAIT_CNT_W)) begin : g_wait_range
      $error("mem_access_ctrl: WAIT_CYCLES must be in 0..15");
    end
  endgenerate

  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYCLES);

  state_t                state;
  state_t                state_nxt;
  op_t                   op_q;
  logic                  req_one;
  logic                  req_both;
  logic                  accept;
  logic                  cnt_zero;
  logic                  access_end;
  logic [WAIT_CNT_W-1:0] cnt;

  assign req_one    = bus.MemRead ^ bus.MemWrite;
  assign req_both   = bus.MemRead & bus.MemWrite;
  assign accept     = (state == IDLE) && req_one;
  assign access_end = (state == ACCESS) && cnt_zero;

  mem_wait_counter #(.W(WAIT_CNT_W)) u_wait (
    .clock    (clock),
    .reset    (reset),
    .load     (accept),
    .load_val (WAIT_LOAD),
    .dec      (state == ACCESS),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Enables are decoded from registered state so an async reset drops them at once
  always_comb begin
    state_nxt       = state;
    bus.stall       = 1'b0;
    bus.mem_re      = 1'b0;
    bus.mem_we      = 1'b0;
    bus.rdata_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.stall = req_one;
        if (req_one) state_nxt = ACCESS;
      end
      ACCESS: begin
        bus.stall  = 1'b1;
        bus.mem_re = (op_q == OP_RD);
        bus.mem_we = (op_q == OP_WR);
        if (cnt_zero) state_nxt = DONE;
      end
      DONE: begin
        bus.rdata_valid = (op_q == OP_RD);
        state_nxt       = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      op_q          <= OP_RD;
      bus.rdata     <= '0;
      bus.req_err   <= 1'b0;
    end else begin
      bus.req_err <= (state == IDLE) && req_both;
      if (accept) begin
        bus.mem_addr  <= bus.AddrSel ? bus.pc_addr : bus.reg_addr;
        bus.mem_wdata <= bus.wdata;
        op_q          <= bus.MemWrite ? OP_WR : OP_RD;
      end
      if (access_end && (op_q == OP_RD)) begin
        bus.rdata <= bus.mem_rdata;
      end
    end
  end

`ifdef MEM_ACCESS_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (access_end) begin
      if (op_q == OP_RD) rd_count <= rd_count + 16'd1;
      else               wr_count <= wr_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed self-checking bench for mem_access_ctrl (WAIT_CYCLES 1, 3, 0)
module tb_mem_access_ctrl;
  import mem_pkg::*;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;

  mem_access_ctrl_if #(.AW(8), .DW(8)) if1 ();
  mem_access_ctrl_if #(.AW(8), .DW(8)) if3 ();
  mem_access_ctrl_if #(.AW(8), .DW(8)) if0 ();

`ifdef MEM_ACCESS_STATS_EN
  logic [15:0] rd1, wr1, rd3, wr3, rd0, wr0;
`endif

  mem_access_ctrl #(.AW(8), .DW(8), .WAIT_CYCLES(1)) dut1 (
    .clock (clock), .reset (reset), .bus (if1)
`ifdef MEM_ACCESS_STATS_EN
    , .rd_count (rd1), .wr_count (wr1)
`endif
  );

  mem_access_ctrl #(.AW(8), .DW(8), .WAIT_CYCLES(3)) dut3 (
    .clock (clock), .reset (reset), .bus (if3)
`ifdef MEM_ACCESS_STATS_EN
    , .rd_count (rd3), .wr_count (wr3)
`endif
  );

  mem_access_ctrl #(.AW(8), .DW(8), .WAIT_CYCLES(0)) dut0 (
    .clock (clock), .reset (reset), .bus (if0)
`ifdef MEM_ACCESS_STATS_EN
    , .rd_count (rd0), .wr_count (wr0)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if (if1.mem_addr !== 8'h00 || if1.mem_wdata !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_addr_data: mem_addr=%h mem_wdata=%h, expected 00 00", if1.mem_addr, if1.mem_wdata);
    end
    n_checks++;
    if ({if1.mem_re, if1.mem_we, if1.stall, if1.rdata_valid, if1.req_err} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: re/we/stall/rv/err=%b, expected 00000",
               {if1.mem_re, if1.mem_we, if1.stall, if1.rdata_valid, if1.req_err});
    end
    n_checks++;
    if (if1.rdata !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_rdata: rdata=%h, expected 00", if1.rdata);
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_access();
    int we_cnt;
    if3.AddrSel  = 1'b0;
    if3.reg_addr = 8'h44;
    if3.wdata    = 8'h66;
    if3.MemWrite = 1'b1;
    tick();
    if3.MemWrite = 1'b0;
    n_checks++;
    if (if3.mem_we !== 1'b1 || if3.mem_addr !== 8'h44) begin
      n_fail++;
      $display("FAIL rst_mid_first_cycle: mem_we=%b mem_addr=%h, expected 1 44", if3.mem_we, if3.mem_addr);
    end
    tick();
    reset = 1'b1;
    #1;
    n_checks++;
    if (if3.mem_we !== 1'b0 || if3.stall !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_drop: mem_we=%b stall=%b, expected 0 0", if3.mem_we, if3.stall);
    end
    n_checks++;
    if (dut3.state !== IDLE || if3.mem_addr !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_mid_state: state=%0d mem_addr=%h, expected 0 00", dut3.state, if3.mem_addr);
    end
    tick();
    reset = 1'b0;
    we_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (if3.mem_we === 1'b1) we_cnt++;
    end
    n_checks++;
    if (we_cnt !== 0 || if3.rdata !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_mid_no_retry: we_cycles=%0d rdata=%h, expected 0 00", we_cnt, if3.rdata);
    end
  endtask

  task automatic test_fetch();
    int re_cnt;
    int rv_cnt;
    if1.AddrSel   = 1'b1;
    if1.pc_addr   = 8'h10;
    if1.reg_addr  = 8'hEE;
    if1.mem_rdata = 8'hA5;
    if1.MemRead   = 1'b1;
    #1;
    n_checks++;
    if (if1.stall !== 1'b1) begin
      n_fail++;
      $display("FAIL fetch_stall_idle: stall=%b, expected 1", if1.stall);
    end
    tick();
    if1.MemRead = 1'b0;
    n_checks++;
    if (if1.mem_re !== 1'b1 || if1.mem_addr !== 8'h10 || if1.stall !== 1'b1) begin
      n_fail++;
      $display("FAIL fetch_access: mem_re=%b mem_addr=%h stall=%b, expected 1 10 1",
               if1.mem_re, if1.mem_addr, if1.stall);
    end
    re_cnt = 1;
    rv_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (if1.mem_re === 1'b1) re_cnt++;
      if (if1.rdata_valid === 1'b1) begin
        rv_cnt++;
        n_checks++;
        if (i !== 1 || if1.rdata !== 8'hA5 || if1.stall !== 1'b0) begin
          n_fail++;
          $display("FAIL fetch_done: cycle=%0d rdata=%h stall=%b, expected cycle 1 A5 0", i, if1.rdata, if1.stall);
        end
      end
    end
    n_checks++;
    if (re_cnt !== 2 || rv_cnt !== 1) begin
      n_fail++;
      $display("FAIL fetch_lengths: re_cycles=%0d rv_pulses=%0d, expected 2 1", re_cnt, rv_cnt);
    end
    n_checks++;
    if (if1.rdata !== 8'hA5) begin
      n_fail++;
      $display("FAIL fetch_hold: rdata=%h, expected A5", if1.rdata);
    end
  endtask

  task automatic test_store();
    int we_cnt;
    int bad;
    if1.AddrSel   = 1'b0;
    if1.pc_addr   = 8'h77;
    if1.reg_addr  = 8'h3C;
    if1.wdata     = 8'h5A;
    if1.mem_rdata = 8'h11;
    if1.MemWrite  = 1'b1;
    tick();
    if1.MemWrite = 1'b0;
    if1.reg_addr = 8'h99;
    if1.wdata    = 8'hFF;
    we_cnt = 0;
    bad    = 0;
    for (int i = 0; i < 5; i++) begin
      if (if1.mem_we === 1'b1) begin
        we_cnt++;
        if (if1.mem_addr !== 8'h3C || if1.mem_wdata !== 8'h5A) bad++;
      end
      if (if1.rdata_valid !== 1'b0 || if1.mem_re !== 1'b0) bad++;
      tick();
    end
    n_checks++;
    if (we_cnt !== 2) begin
      n_fail++;
      $display("FAIL store_we_len: we_cycles=%0d, expected 2", we_cnt);
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL store_stable: bad_cycles=%0d, expected 0", bad);
    end
    n_checks++;
    if (if1.rdata !== 8'hA5) begin
      n_fail++;
      $display("FAIL store_rdata_hold: rdata=%h, expected A5", if1.rdata);
    end
  endtask

  task automatic test_req_err();
    if1.MemRead  = 1'b1;
    if1.MemWrite = 1'b1;
    #1;
    n_checks++;
    if (if1.stall !== 1'b0) begin
      n_fail++;
      $display("FAIL req_err_stall: stall=%b, expected 0", if1.stall);
    end
    tick();
    if1.MemRead  = 1'b0;
    if1.MemWrite = 1'b0;
    n_checks++;
    if (if1.req_err !== 1'b1 || if1.mem_re !== 1'b0 || if1.mem_we !== 1'b0 || dut1.state !== IDLE) begin
      n_fail++;
      $display("FAIL req_err_pulse: req_err=%b re=%b we=%b state=%0d, expected 1 0 0 0",
               if1.req_err, if1.mem_re, if1.mem_we, dut1.state);
    end
    tick();
    n_checks++;
    if (if1.req_err !== 1'b0 || if1.mem_re !== 1'b0) begin
      n_fail++;
      $display("FAIL req_err_clear: req_err=%b mem_re=%b, expected 0 0", if1.req_err, if1.mem_re);
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp_rv;
    exp_rv = 9'b010_010_010;
    if0.AddrSel   = 1'b1;
    if0.pc_addr   = 8'h20;
    if0.mem_rdata = 8'h20;
    if0.MemRead   = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      n_checks++;
      if (if0.rdata_valid !== exp_rv[9-i] || if0.stall !== ~exp_rv[9-i]) begin
        n_fail++;
        $display("FAIL b2b_pattern: cycle=%0d rdata_valid=%b stall=%b, expected %b %b",
                 i, if0.rdata_valid, if0.stall, exp_rv[9-i], ~exp_rv[9-i]);
      end
      if (exp_rv[9-i]) begin
        n_checks++;
        if (if0.rdata !== 8'(8'h20 + i - 1)) begin
          n_fail++;
          $display("FAIL b2b_rdata: cycle=%0d rdata=%h, expected %h", i, if0.rdata, 8'(8'h20 + i - 1));
        end
      end
      if0.mem_rdata = 8'(8'h20 + i);
    end
    if0.MemRead = 1'b0;
    tick();
    tick();
  endtask

`ifdef MEM_ACCESS_STATS_EN
  task automatic test_stats();
    n_checks++;
    if (rd1 !== 16'd1 || wr1 !== 16'd1) begin
      n_fail++;
      $display("FAIL stats_counts: rd=%0d wr=%0d, expected 1 1", rd1, wr1);
    end
    force dut1.rd_count = 16'hFFFF;
    #1;
    release dut1.rd_count;
    if1.AddrSel = 1'b1;
    if1.pc_addr = 8'h01;
    if1.MemRead = 1'b1;
    tick();
    if1.MemRead = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    n_checks++;
    if (rd1 !== 16'h0000 || wr1 !== 16'd1) begin
      n_fail++;
      $display("FAIL stats_wrap: rd=%h wr=%0d, expected 0000 1", rd1, wr1);
    end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    if1.MemRead = 1'b0; if1.MemWrite = 1'b0; if1.AddrSel = 1'b0;
    if1.pc_addr = '0; if1.reg_addr = '0; if1.wdata = '0; if1.mem_rdata = '0;
    if3.MemRead = 1'b0; if3.MemWrite = 1'b0; if3.AddrSel = 1'b0;
    if3.pc_addr = '0; if3.reg_addr = '0; if3.wdata = '0; if3.mem_rdata = '0;
    if0.MemRead = 1'b0; if0.MemWrite = 1'b0; if0.AddrSel = 1'b0;
    if0.pc_addr = '0; if0.reg_addr = '0; if0.wdata = '0; if0.mem_rdata = '0;

    test_reset();
    test_reset_mid_access();
    test_fetch();
    test_store();
    test_req_err();
    test_back_to_back();
`ifdef MEM_ACCESS_STATS_EN
    test_stats();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
